// File: rtl/mac_seq_ctrl.sv
// mac_seq_ctrl: sequencer for the pipelined 8.8 fixed-point multiplier in the MAC path.
//
// On a start command it streams vec_len operand pairs into an external multiplier using a
// valid/ready handshake. A valid shift register follows the products through the multiplier,
// which has no valid signal of its own. The products are summed, and the dot product is
// returned on a held result handshake.
//
// Ports:
//   clk, reset          clock (posedge) and synchronous active-high reset
//   start, vec_len      one-cycle command and vector length (honoured only when idle)
//   op_valid, op_ready  operand pair handshake; op_in / op_w are 8.8 signed operands
//   mult_in, mult_w     operands to the multiplier (zero on bubbles)
//   mult_out            product from the multiplier, MULT_LAT cycles after mult_in/mult_w
//   busy                high whenever not idle
//   res_valid/res_ready result handshake; result is 8.8 signed, ovf flags clamping
//
// Build option: define SAT_EN to clamp the result to the 16-bit range and report ovf.
// Without SAT_EN the result wraps and ovf is tied low.

module mac_seq_ctrl #(
  parameter int unsigned MULT_LAT = 5,
  parameter int unsigned LEN_W    = 8,
  parameter int unsigned ACC_W    = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [LEN_W-1:0] vec_len,
  input  logic             op_valid,
  output logic             op_ready,
  input  logic [15:0]      op_in,
  input  logic [15:0]      op_w,
  output logic [15:0]      mult_in,
  output logic [15:0]      mult_w,
  input  logic [15:0]      mult_out,
  output logic             busy,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [15:0]      result,
  output logic             ovf
);

  typedef enum logic [1:0] {StIdle, StFeed, StDrain, StDone} state_e;

  localparam logic [LEN_W-1:0] LenOne = LEN_W'(1);

  state_e              state_q, state_d;
  logic [LEN_W-1:0]    len_q;
  logic [LEN_W-1:0]    issue_cnt_q;
  logic [MULT_LAT-1:0] vld_sr_q;
  logic [ACC_W-1:0]    acc_q;
  logic [15:0]         result_q;
  logic                ovf_q;

  logic                fire;
  logic                start_go;
  logic [ACC_W-1:0]    prod_ext;
  logic [15:0]         result_d;
  logic                ovf_d;

  assign prod_ext = {{(ACC_W-16){mult_out[15]}}, mult_out};

  // Next state and handshake outputs.
  always_comb begin
    state_d  = state_q;
    op_ready = 1'b0;
    start_go = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          start_go = 1'b1;
          state_d  = (vec_len != '0) ? StFeed : StDone;
        end
      end
      StFeed: begin
        op_ready = (issue_cnt_q < len_q);
        if (op_valid && op_ready && (issue_cnt_q == len_q - LenOne)) begin
          state_d = StDrain;
        end
      end
      StDrain: begin
        // All-zero valid register also means no accumulate is pending this cycle.
        if (vld_sr_q == '0) begin
          state_d = StDone;
        end
      end
      StDone: begin
        if (res_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign fire = op_valid & op_ready;

  // Bubbles present zero operands so a stray product can never be non-zero.
  always_comb begin
    mult_in = 16'h0000;
    mult_w  = 16'h0000;
    if (fire) begin
      mult_in = op_in;
      mult_w  = op_w;
    end
  end

  // Result formatting from the final accumulator value.
  always_comb begin
`ifdef SAT_EN
    result_d = acc_q[15:0];
    ovf_d    = 1'b0;
    // Bits above bit 15 must all match the sign for the value to fit in 16 bits.
    if (!((&acc_q[ACC_W-1:15]) || (~|acc_q[ACC_W-1:15]))) begin
      ovf_d    = 1'b1;
      result_d = acc_q[ACC_W-1] ? 16'h8000 : 16'h7FFF;
    end
`else
    result_d = acc_q[15:0];
    ovf_d    = 1'b0;
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      len_q       <= '0;
      issue_cnt_q <= '0;
      vld_sr_q    <= '0;
      acc_q       <= '0;
      result_q    <= 16'h0000;
      ovf_q       <= 1'b0;
    end else begin
      state_q <= state_d;
      if (start_go) begin
        len_q       <= vec_len;
        issue_cnt_q <= '0;
        vld_sr_q    <= '0;
        acc_q       <= '0;
      end else begin
        vld_sr_q <= {vld_sr_q[MULT_LAT-2:0], fire};
        if (fire) begin
          issue_cnt_q <= issue_cnt_q + LenOne;
        end
        if (vld_sr_q[MULT_LAT-1]) begin
          acc_q <= acc_q + prod_ext;
        end
      end
      // Result and ovf are captured only on entry to DONE and held until accepted.
      if (state_q == StIdle && start_go && state_d == StDone) begin
        result_q <= 16'h0000;
        ovf_q    <= 1'b0;
      end else if (state_q == StDrain && state_d == StDone) begin
        result_q <= result_d;
        ovf_q    <= ovf_d;
      end
    end
  end

  assign busy      = (state_q != StIdle);
  assign res_valid = (state_q == StDone);
  assign result    = result_q;
  assign ovf       = ovf_q;

endmodule
